// File: rtl/spi_flash_reader.sv
// SPI-flash (mode 0, single-bit) read initiator: sends READ + 24-bit address, streams bytes out.
// Define SPI_FLASH_FAST_READ_EN to issue FAST READ (0x0B) with 8 dummy clocks after the address.
module spi_flash_reader #(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned LEN_W   = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             start_i,
   input  logic [23:0]      addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [7:0]       rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic             flash_csb_o,
   output logic             flash_clk_o,
   output logic             flash_io0_o,
   input  logic             flash_io1_i
);

`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [7:0] READ_CMD = 8'h0B;
   localparam logic [5:0] HDR_BITS = 6'd40;
`else
   localparam logic [7:0] READ_CMD = 8'h03;
   localparam logic [5:0] HDR_BITS = 6'd32;
`endif
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CS_SETUP, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_CS_HOLD, ST_CS_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       div_q, div_d;
   logic             sck_q, sck_d;
   logic             csb_q, csb_d;
   logic [31:0]      tx_q, tx_d;
   logic [5:0]       hdr_q, hdr_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       rx_q, rx_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             cap_q, cap_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;

   // Phase of the bit that follows c completed header rising edges.
   function automatic state_t hdr_state(input logic [5:0] c);
      if (c < 6'd8)
         return ST_CMD;
      else if (c < 6'd32)
         return ST_ADDR;
      else if (c < HDR_BITS)
         return ST_DUMMY;
      else
         return ST_DATA;
   endfunction

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         sck_q      <= 1'b0;
         csb_q      <= 1'b1;
         tx_q       <= '0;
         hdr_q      <= '0;
         bit_q      <= '0;
         rx_q       <= '0;
         len_q      <= '0;
         cap_q      <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         sck_q      <= sck_d;
         csb_q      <= csb_d;
         tx_q       <= tx_d;
         hdr_q      <= hdr_d;
         bit_q      <= bit_d;
         rx_q       <= rx_d;
         len_q      <= len_d;
         cap_q      <= cap_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      sck_d      = sck_q;
      csb_d      = csb_q;
      tx_d       = tx_q;
      hdr_d      = hdr_q;
      bit_d      = bit_q;
      rx_d       = rx_q;
      len_d      = len_q;
      cap_d      = 1'b0;
      done_d     = 1'b0;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;

      if (rd_valid_q && rd_ready_i)
         rd_valid_d = 1'b0;
      // Captured byte lands one cycle after its 8th rising edge; the slot is free by then.
      if (cap_q) begin
         rd_data_d  = rx_q;
         rd_valid_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_CS_SETUP;
                  csb_d   = 1'b0;
                  tx_d    = {READ_CMD, addr_i};
                  len_d   = len_i;
                  div_d   = '0;
                  hdr_d   = '0;
               end
            end
         end
         ST_CS_SETUP: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               sck_d   = 1'b1;
               hdr_d   = 6'd1;
               state_d = ST_CMD;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 8'd1;
            end else if (sck_q) begin
               div_d = '0;
               sck_d = 1'b0;
               tx_d  = {tx_q[30:0], 1'b0};
               if (state_q == ST_DATA) begin
                  if (len_q == '0)
                     state_d = ST_CS_HOLD;
               end else begin
                  state_d = hdr_state(hdr_q);
                  bit_d   = '0;
               end
            end else if (!(state_q == ST_DATA && bit_q == 3'd7 && rd_valid_q && !rd_ready_i)) begin
               // The 8th rise of a byte waits here while the previous byte is unconsumed.
               div_d = '0;
               sck_d = 1'b1;
               if (state_q == ST_DATA) begin
                  rx_d  = {rx_q[6:0], flash_io1_i};
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     cap_d = 1'b1;
                     len_d = len_q - LEN_W'(1);
                  end
               end else begin
                  hdr_d = hdr_q + 6'd1;
               end
            end
         end
         ST_CS_HOLD: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               csb_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_CS_GAP;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         ST_CS_GAP: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = ST_IDLE;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign rd_data_o   = rd_data_q;
   assign rd_valid_o  = rd_valid_q;
   assign flash_csb_o = csb_q;
   assign flash_clk_o = sck_q;
   assign flash_io0_o = tx_q[31];

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

SPI-flash read initiator (mode 0, single-bit I/O). It issues a READ command, a 24-bit address and streams `len` bytes back over a valid/ready byte interface. It sits on the user-project side and drives the same external serial flash device the management core boots from. It is used to fetch coefficient and data tables without firmware involvement.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `wb_clk_i` cycles. Legal range is 1–255.
- `LEN_W`, default 16: width of the byte-count input.

Ports:
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: single-cycle request. Sampled only while `busy_o` = 0.
- `addr_i` in 24: flash byte address. Latched on accepted `start_i`.
- `len_i` in LEN_W: number of bytes to read. Latched on accepted `start_i`.
- `busy_o` out 1: a transaction is in progress.
- `done_o` out 1: one-cycle pulse at transaction end.
- `rd_data_o` out 8: received byte, MSB first on the wire.
- `rd_valid_o` out 1: `rd_data_o` holds a byte.
- `rd_ready_i` in 1: consumer accepts the byte. A transfer occurs when `rd_valid_o` & `rd_ready_i`.
- `flash_csb_o` out 1: chip select, active low.
- `flash_clk_o` out 1: SCK, idles low.
- `flash_io0_o` out 1: MOSI.
- `flash_io1_i` in 1: MISO.

## Operation
- States: IDLE → CS_SETUP → CMD (8 bits) → ADDR (24 bits, MSB first) → [DUMMY] → DATA (8·len bits) → CS_HOLD → CS_GAP → IDLE.
- IDLE accepts `start_i`:
  - `len_i` = 0: no flash activity; `done_o` pulses the next cycle.
  - `len_i` ≠ 0: latch address and length, set `busy_o`, drive `flash_csb_o` low.
- `start_i` while `busy_o` = 1 is ignored. No queueing.
- Command byte is 0x03.
- MOSI changes only while SCK is low, i.e. at the falling edge or at CS assertion for the first bit. It is held 0 during DATA.
- MISO is sampled on the `wb_clk_i` edge that drives SCK high. Bits are shifted MSB first.
- On the 8th rising edge of each byte, the shift register is copied to `rd_data_o` and `rd_valid_o` is set next cycle. `rd_valid_o` stays high until the transfer.
- Backpressure: SCK is held low in front of a byte's 8th rising edge while `rd_valid_o` = 1 and `rd_ready_i` = 0. No byte is ever dropped or overwritten.
- The byte counter decrements on each byte capture. After the last byte, SCK returns low, then CS_HOLD runs.
- CS_HOLD lasts `CLK_DIV` cycles. `flash_csb_o` then rises and `done_o` pulses in that same cycle.
- CS_GAP keeps `busy_o` high for `CLK_DIV` more cycles. This guarantees the minimum CSB-high time before the next transaction.
- `done_o` fires even if the last byte is still pending on `rd_valid_o`. The consumer drains it normally.
- Reset, asynchronous and at any time including mid-transaction:
  - `flash_csb_o` = 1, `flash_clk_o` = 0, `flash_io0_o` = 0.
  - `busy_o` = 0, `done_o` = 0, `rd_valid_o` = 0, `rd_data_o` = 0x00.
  - State returns to IDLE and the partial transfer is abandoned.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `start_i` accepted in cycle 0: `flash_csb_o` low and the first MOSI bit valid in cycle 1. First SCK rise occurs at cycle 1 + `CLK_DIV`.
- SCK period is 2·`CLK_DIV`, with exactly `CLK_DIV` cycles high and `CLK_DIV` cycles low except during stalls.
- Without stalls, byte k (k = 0..len−1) appears on `rd_valid_o` in cycle 1 + `CLK_DIV` + 2·`CLK_DIV`·(32 + 8k + 7) + 1.
- With `rd_ready_i` held high, throughput is one byte per 16·`CLK_DIV` cycles.
- `busy_o` falls `CLK_DIV` cycles after `done_o`.

## Configuration
- `SPI_FLASH_FAST_READ_EN` defined:
  - Command is 0x0B.
  - A DUMMY state of 8 SCK cycles (MOSI = 0) follows ADDR.
  - All DATA timings shift by 16·`CLK_DIV` cycles.
- Undefined: command is 0x03 and there is no DUMMY state.

## Test plan
- Basic read:
  - Stimulus: `CLK_DIV`=2, `addr_i`=0x000010, `len_i`=4, flash model preloaded with 0xA1,0xB2,0xC3,0xD4, `rd_ready_i`=1.
  - Required: bytes delivered in that order; MOSI carries 0x03,0x00,0x00,0x10; exactly 64 SCK rises; one `done_o` pulse.
- Zero length:
  - Stimulus: `len_i`=0.
  - Required: `flash_csb_o` stays 1, `done_o` pulses the next cycle, no SCK edges.
- Backpressure:
  - Stimulus: `rd_ready_i`=0 for 100 cycles after the first `rd_valid_o`.
  - Required: SCK frozen low before the 8th rise of byte 1; `rd_data_o`=0xA1 stable; after release, byte 1 = 0xB2 arrives intact.
- Busy/ignore:
  - Stimulus: second `start_i` pulsed mid-DATA with `addr_i`=0x000100.
  - Required: ignored; original 4 bytes only; after `done_o`, `flash_csb_o` high for ≥ `CLK_DIV` cycles before a new start is accepted.
- Reset mid-transaction:
  - Stimulus: assert `wb_rst_i` during ADDR, asynchronously between clock edges.
  - Required: `flash_csb_o`=1 and `flash_clk_o`=0 immediately; all outputs at reset values; a subsequent read at 0x000010 returns 0xA1.
- Fast-read build:
  - Stimulus: compile with `SPI_FLASH_FAST_READ_EN` and repeat the basic read.
  - Required: command 0x0B; 8 dummy SCK cycles; identical data; first `rd_valid_o` 32 cycles later than in the basic read.
